// File: rtl/regfile_dump_if.sv
// ---------------------------------------------------------------------------
// regfile_dump_if : borrowed RegisterFile read port 1 plus the TX byte stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_dump_if #(
  parameter int PROC_BITS      = 32,
  parameter int REG_ADDRS_BITS = 5,
  parameter int BYTE_BITS      = 8
);
  logic                      o_rf_sel;
  logic [REG_ADDRS_BITS-1:0] o_rf_read_addr;
  logic [PROC_BITS-1:0]      i_rf_read_data;
  logic [BYTE_BITS-1:0]      o_tx_data;
  logic                      o_tx_valid;
  logic                      i_tx_ready;

  modport master (
    output o_rf_sel, o_rf_read_addr, o_tx_data, o_tx_valid,
    input  i_rf_read_data, i_tx_ready
  );

  modport slave (
    input  o_rf_sel, o_rf_read_addr, o_tx_data, o_tx_valid,
    output i_rf_read_data, i_tx_ready
  );
endinterface

`default_nettype wire

// File: rtl/regfile_dump_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_dump_ctrl : streams every register MSB-first as bytes while halted
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_dump_ctrl #(
  parameter int PROC_BITS      = 32,
  parameter int REG_ADDRS_BITS = 5,
  parameter int NUM_REGS       = 32,
  parameter int BYTE_BITS      = 8
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_cpu_halted,
  input  logic i_start,
  input  logic i_abort,
  output logic o_busy,
  output logic o_done,
  regfile_dump_if.master bus
);

  localparam int NBYTES = PROC_BITS / BYTE_BITS;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [REG_ADDRS_BITS-1:0] LAST_IDX  = REG_ADDRS_BITS'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]          LAST_BYTE = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_SEND = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                    state, state_n;
  logic [REG_ADDRS_BITS-1:0] idx, idx_n;
  logic [CNT_W-1:0]          byte_cnt, byte_cnt_n;
  logic [PROC_BITS-1:0]      shreg, shreg_n;

  always_comb begin
    state_n    = state;
    idx_n      = idx;
    byte_cnt_n = byte_cnt;
    shreg_n    = shreg;
    case (state)
      S_IDLE: begin
        if (i_start && i_cpu_halted) begin
          state_n = S_ADDR;
          idx_n   = '0;
        end
      end
      S_ADDR: begin
        shreg_n    = bus.i_rf_read_data;
        byte_cnt_n = '0;
        state_n    = S_SEND;
      end
      S_SEND: begin
        if (bus.i_tx_ready) begin
          shreg_n    = shreg << BYTE_BITS;
          byte_cnt_n = byte_cnt + CNT_W'(1);
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt_n = '0;
            if (idx == LAST_IDX) begin
              state_n = S_DONE;
            end else begin
              idx_n   = idx + REG_ADDRS_BITS'(1);
              state_n = S_ADDR;
            end
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Abort wins over a same-cycle handshake, so that byte is never counted
    if (i_abort && (state != S_IDLE)) begin
      state_n    = S_IDLE;
      idx_n      = '0;
      byte_cnt_n = '0;
      shreg_n    = '0;
    end
  end

  // Outputs are registered from the next-state values so they line up with state
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state              <= S_IDLE;
      idx                <= '0;
      byte_cnt           <= '0;
      shreg              <= '0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      bus.o_rf_sel       <= 1'b0;
      bus.o_rf_read_addr <= '0;
      bus.o_tx_valid     <= 1'b0;
      bus.o_tx_data      <= '0;
    end else begin
      state              <= state_n;
      idx                <= idx_n;
      byte_cnt           <= byte_cnt_n;
      shreg              <= shreg_n;
      o_busy             <= (state_n != S_IDLE);
      o_done             <= (state_n == S_DONE);
      bus.o_rf_sel       <= (state_n == S_ADDR) || (state_n == S_SEND);
      bus.o_rf_read_addr <= idx_n;
      bus.o_tx_valid     <= (state_n == S_SEND);
      bus.o_tx_data      <= shreg_n[PROC_BITS-1 -: BYTE_BITS];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_dump_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_dump_ctrl : scoreboard bench for the register-file dump sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_dump_ctrl;
  localparam int PROC_BITS      = 32;
  localparam int REG_ADDRS_BITS = 5;
  localparam int NUM_REGS       = 32;
  localparam int BYTE_BITS      = 8;
  localparam int NBYTES         = PROC_BITS / BYTE_BITS;
  localparam int TOTAL          = NUM_REGS * NBYTES;
  localparam int MAX_CYC        = 3000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_halted = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  regfile_dump_if #(.PROC_BITS(PROC_BITS), .REG_ADDRS_BITS(REG_ADDRS_BITS),
                    .BYTE_BITS(BYTE_BITS)) bus ();

  logic [PROC_BITS-1:0] regs [NUM_REGS];
  logic [7:0] exp_q [$];
  logic [7:0] got [$];
  int tests_run = 0;
  int tests_failed = 0;
  int done_count = 0;
  logic prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always #5 clk = ~clk;

  assign bus.i_rf_read_data = regs[bus.o_rf_read_addr];

  regfile_dump_ctrl #(
    .PROC_BITS(PROC_BITS), .REG_ADDRS_BITS(REG_ADDRS_BITS),
    .NUM_REGS(NUM_REGS), .BYTE_BITS(BYTE_BITS)
  ) dut (
    .clk(clk), .i_rst_n(rst_n), .i_cpu_halted(cpu_halted), .i_start(start),
    .i_abort(abort), .o_busy(busy), .o_done(done), .bus(bus)
  );

  // Byte monitor: a byte is sent when valid&&ready are seen before the edge without abort
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        tests_run++;
        if (bus.o_tx_valid !== 1'b1 || bus.o_tx_data !== prev_data) begin
          tests_failed++;
          $display("FAIL hold_stable: valid=%b data=%02h, required valid=1 data=%02h",
                   bus.o_tx_valid, bus.o_tx_data, prev_data);
        end
      end
      if (bus.o_tx_valid === 1'b1 && bus.i_tx_ready === 1'b1 && abort === 1'b0) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL extra_byte: got %02h, required no byte", bus.o_tx_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.o_tx_data !== e) begin
            tests_failed++;
            $display("FAIL byte[%0d]: got %02h, required %02h", got.size(), bus.o_tx_data, e);
          end
        end
        got.push_back(bus.o_tx_data);
      end
      prev_stall = bus.o_tx_valid && !bus.i_tx_ready && !abort;
      prev_data  = bus.o_tx_data;
      if (done === 1'b1) done_count++;
    end
  end

  task automatic push_expected();
    exp_q.delete();
    for (int k = 0; k < NUM_REGS; k++) begin
      for (int b = NBYTES - 1; b >= 0; b--) begin
        exp_q.push_back(regs[k][b*8 +: 8]);
      end
    end
  endtask

  task automatic run_dump(input bit rand_ready, input int repulse_at, input int halt_drop_at,
                          output int first_valid, output int done_cyc);
    int cyc;
    push_expected();
    got.delete();
    done_count  = 0;
    first_valid = -1;
    done_cyc    = -1;
    @(posedge clk); #1;
    start = 1'b1;
    bus.i_tx_ready = 1'b1;
    cyc = 0;
    while (done_cyc < 0 && cyc < MAX_CYC) begin
      @(posedge clk); cyc++; #1;
      start = (repulse_at != 0 && cyc == repulse_at);
      if (halt_drop_at != 0 && cyc == halt_drop_at) cpu_halted = 1'b0;
      bus.i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bus.o_tx_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (done === 1'b1) done_cyc = cyc;
    end
    cpu_halted = 1'b1;
    start = 1'b0;
    bus.i_tx_ready = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; cpu_halted = 1'b1; bus.i_tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, done, bus.o_rf_sel, bus.o_tx_valid} !== 4'b0 ||
        bus.o_rf_read_addr !== '0 || bus.o_tx_data !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy=%b done=%b sel=%b valid=%b addr=%0d data=%02h, required all 0",
               busy, done, bus.o_rf_sel, bus.o_tx_valid, bus.o_rf_read_addr, bus.o_tx_data);
    end
    @(posedge clk); #1;
    start = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || bus.o_rf_sel !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_after_reset: busy=%b sel=%b, required 0 0", busy, bus.o_rf_sel);
    end
  endtask

  task automatic check_full_dump(input string tag, input int first_valid, input int done_cyc,
                                 input bit exact);
    tests_run++;
    if (exact && first_valid !== 2) begin
      tests_failed++;
      $display("FAIL %s first_valid: got cycle %0d, required 2", tag, first_valid);
    end
    tests_run++;
    if ((exact && done_cyc !== 161) || (!exact && done_cyc < 161)) begin
      tests_failed++;
      $display("FAIL %s done_cycle: got %0d, required %s161", tag, done_cyc, exact ? "" : ">=");
    end
    tests_run++;
    if (got.size() !== TOTAL || exp_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL %s byte_count: got %0d left %0d, required %0d left 0",
               tag, got.size(), exp_q.size(), TOTAL);
    end
    tests_run++;
    if (done_count !== 1) begin
      tests_failed++;
      $display("FAIL %s done_pulses: got %0d, required 1", tag, done_count);
    end
    tests_run++;
    if (bus.o_rf_sel !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s after_done: sel=%b busy=%b, required 0 0", tag, bus.o_rf_sel, busy);
    end
  endtask

  task automatic test_full_dump();
    int fv, dc;
    logic [7:0] head [8];
    logic [7:0] mid [4];
    head = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h01};
    mid  = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_dump(1'b0, 0, 0, fv, dc);
    check_full_dump("full", fv, dc, 1'b1);
    if (got.size() >= 24) begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (got[i] !== head[i]) begin
          tests_failed++;
          $display("FAIL head_byte[%0d]: got %02h, required %02h", i, got[i], head[i]);
        end
      end
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got[20+i] !== mid[i]) begin
          tests_failed++;
          $display("FAIL reg5_byte[%0d]: got %02h, required %02h", i, got[20+i], mid[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int fv, dc;
    run_dump(1'b1, 0, 0, fv, dc);
    check_full_dump("backpressure", fv, dc, 1'b0);
  endtask

  task automatic test_start_ignore();
    int fv, dc;
    logic bad;
    cpu_halted = 1'b0;
    bad = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0 || bus.o_tx_valid !== 1'b0) bad = 1'b1;
    end
    tests_run++;
    if (bad !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_not_halted: activity seen=%b, required 0", bad);
    end
    cpu_halted = 1'b1;
    run_dump(1'b0, 50, 30, fv, dc);
    check_full_dump("repulse", fv, dc, 1'b1);
  endtask

  task automatic test_abort();
    int fv, dc, cyc;
    push_expected();
    got.delete();
    done_count = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (got.size() < 14 && cyc < MAX_CYC) begin
      @(posedge clk); #2; cyc++;
    end
    tests_run++;
    if (bus.o_tx_valid !== 1'b1 || bus.o_rf_read_addr !== 5'd3 || bus.o_tx_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL abort_point: valid=%b addr=%0d data=%02h, required 1 3 00",
               bus.o_tx_valid, bus.o_rf_read_addr, bus.o_tx_data);
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    @(negedge clk);
    tests_run++;
    if ({busy, bus.o_tx_valid, bus.o_rf_sel, done} !== 4'b0 ||
        bus.o_tx_data !== '0 || bus.o_rf_read_addr !== '0) begin
      tests_failed++;
      $display("FAIL abort_outputs: busy=%b valid=%b sel=%b done=%b data=%02h addr=%0d, required all 0",
               busy, bus.o_tx_valid, bus.o_rf_sel, done, bus.o_tx_data, bus.o_rf_read_addr);
    end
    repeat (4) @(negedge clk);
    tests_run++;
    if (done_count !== 0 || got.size() !== 14) begin
      tests_failed++;
      $display("FAIL abort_no_done: done=%0d bytes=%0d, required 0 14", done_count, got.size());
    end
    run_dump(1'b0, 0, 0, fv, dc);
    check_full_dump("after_abort", fv, dc, 1'b1);
  endtask

  task automatic test_async_reset();
    int fv, dc, cyc;
    push_expected();
    got.delete();
    done_count = 0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    cyc = 0;
    while (!(bus.o_rf_read_addr === 5'd10 && bus.o_tx_valid === 1'b1) && cyc < MAX_CYC) begin
      @(posedge clk); #1; cyc++;
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({busy, done, bus.o_rf_sel, bus.o_tx_valid} !== 4'b0 ||
        bus.o_tx_data !== '0 || bus.o_rf_read_addr !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: busy=%b done=%b sel=%b valid=%b data=%02h addr=%0d, required all 0",
               busy, done, bus.o_rf_sel, bus.o_tx_valid, bus.o_tx_data, bus.o_rf_read_addr);
    end
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    tests_run++;
    if (done_count !== 0) begin
      tests_failed++;
      $display("FAIL async_no_done: got %0d, required 0", done_count);
    end
    run_dump(1'b0, 0, 0, fv, dc);
    check_full_dump("after_reset", fv, dc, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < NUM_REGS; k++) regs[k] = 32'h0100_0000 + k;
    regs[5] = 32'hDEAD_BEEF;
    bus.i_tx_ready = 1'b1;
    test_reset();
    test_full_dump();
    test_backpressure();
    test_start_ignore();
    test_abort();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
